// File: rtl/clk_div_bank_pkg.sv
// Shared types for the clock divider bank: divider mode and per-channel config record.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    // Divisor field is sized for the widest supported channel; channels use the low WIDTH bits.
    localparam int unsigned CFG_DIV_W = 32;

    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        div_mode_e            mode;
    } chan_cfg_t;

endpackage

// File: rtl/clk_div_bank_if.sv
// Config request channel of the divider bank: valid/ready handshake carrying channel, divisor and mode.
interface clk_div_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16
);
    import clk_div_pkg::*;

    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_chan;
    logic [WIDTH-1:0] cfg_div;
    div_mode_e       cfg_mode;

    modport master (
        output cfg_valid, cfg_chan, cfg_div, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_div, cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_bank_channel.sv
// One divider slice: counter, shadow config with pending flag, registered clk_out and edge strobes.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      load,
    input  chan_cfg_t load_cfg,
    output logic      pending,
    output logic      clk_out,
    output logic      rise,
    output logic      fall
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_sdiv;
    div_mode_e        r_mode;
    div_mode_e        r_smode;
    logic             r_pend;
    logic             r_clk;
    logic             r_rise;
    logic             r_fall;

    logic w_bnd;
    logic w_apply;
    logic w_clk_n;

    always_comb begin
        w_bnd   = (r_cnt == r_div);
        w_apply = r_pend & (~en | w_bnd);
        w_clk_n = 1'b0;
        // An apply restarts the period low, exactly like a disable.
        if (en && !w_apply) begin
            if (r_mode == MODE_TOGGLE) begin
                w_clk_n = r_clk ^ w_bnd;
            end else begin
                w_clk_n = w_bnd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= WIDTH'(DIV_RESET);
            r_mode  <= MODE_TOGGLE;
            r_sdiv  <= '0;
            r_smode <= MODE_TOGGLE;
            r_pend  <= 1'b0;
            r_clk   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_clk  <= w_clk_n;
            r_rise <= w_clk_n & ~r_clk;
            r_fall <= ~w_clk_n & r_clk;
            if (!en || w_bnd) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_apply) begin
                r_div  <= r_sdiv;
                r_mode <= r_smode;
                r_pend <= 1'b0;
            end else if (load) begin
                r_sdiv  <= load_cfg.div[WIDTH-1:0];
                r_smode <= load_cfg.mode;
                r_pend  <= 1'b1;
            end
        end
    end

    assign pending = r_pend;
    assign clk_out = r_clk;
    assign rise    = r_rise;
    assign fall    = r_fall;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock dividers / tick generators with a shared config port.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    clk_div_bank_if.slave       cfg,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned NSLOT = 1 << CW;

    logic [CHANNELS-1:0] w_pending;
    logic [NSLOT-1:0]    w_pend_slot;
    logic                w_chan_ok;
    chan_cfg_t           w_cfg;

    // Pending flags padded to the full cfg_chan range so out-of-range selects read 0.
    assign w_pend_slot   = NSLOT'(w_pending);
    assign w_chan_ok     = (32'(cfg.cfg_chan) < CHANNELS);
    assign cfg.cfg_ready = ~(w_chan_ok & w_pend_slot[cfg.cfg_chan]);

    always_comb begin
        w_cfg      = '0;
        w_cfg.div  = CFG_DIV_W'(cfg.cfg_div);
        w_cfg.mode = cfg.cfg_mode;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic w_load;
        assign w_load = cfg.cfg_valid & cfg.cfg_ready & w_chan_ok & (cfg.cfg_chan == CW'(i));

        clk_div_channel #(
            .WIDTH     (WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .load     (w_load),
            .load_cfg (w_cfg),
            .pending  (w_pending[i]),
            .clk_out  (clk_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: phase-based reference model plus directed literal checks.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int unsigned CH  = 4;
    localparam int unsigned CHB = 3;
    localparam int unsigned W   = 16;
    localparam int unsigned DR  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, rst_b;
    logic [CH-1:0]  en;
    logic [CHB-1:0] en_b;
    logic [CH-1:0]  clk_out, rise, fall;
    logic [CHB-1:0] clk_out_b, rise_b, fall_b;

    clk_div_bank_if #(.CHANNELS(CH),  .WIDTH(W)) cfg ();
    clk_div_bank_if #(.CHANNELS(CHB), .WIDTH(W)) cfg_b ();

    clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .DIV_RESET(DR)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg),
        .clk_out (clk_out),
        .rise    (rise),
        .fall    (fall)
    );

    // Non-power-of-two bank so an out-of-range cfg_chan is expressible.
    clk_div_bank #(.CHANNELS(CHB), .WIDTH(W), .DIV_RESET(DR)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .en      (en_b),
        .cfg     (cfg_b),
        .clk_out (clk_out_b),
        .rise    (rise_b),
        .fall    (fall_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: phase = running cycles since the channel last restarted.
    int        m_div [CH];
    int        m_sdiv[CH];
    int        m_k   [CH];
    div_mode_e m_mode [CH];
    div_mode_e m_smode[CH];
    bit        m_pend[CH];
    bit        m_clk [CH];
    bit        m_rise[CH];
    bit        m_fall[CH];
    int        kb;

    function automatic bit level_at(input div_mode_e md, input int d, input int k);
        if (md == MODE_TOGGLE) return ((k / (d + 1)) % 2) == 1;
        return (k > 0) && ((k % (d + 1)) == 0);
    endfunction

    always @(posedge clk) begin
        bit acc, apply, nc;
        bit [CHB-1:0] exp_b;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_div[i] = DR;  m_mode[i] = MODE_TOGGLE; m_k[i] = 0; m_pend[i] = 0;
                m_sdiv[i] = 0;  m_smode[i] = MODE_TOGGLE;
                m_clk[i] = 0;   m_rise[i] = 0;  m_fall[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                acc = cfg.cfg_valid && (int'(cfg.cfg_chan) == i) && !m_pend[i];
                if (!en[i]) begin
                    apply = m_pend[i];
                    m_k[i] = 0;
                    nc = 0;
                end else begin
                    apply = m_pend[i] && ((m_k[i] % (m_div[i] + 1)) == m_div[i]);
                    if (apply) begin
                        m_k[i] = 0;
                        nc = 0;
                    end else begin
                        m_k[i]++;
                        nc = level_at(m_mode[i], m_div[i], m_k[i]);
                    end
                end
                if (apply) begin
                    m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; m_pend[i] = 0;
                end
                if (acc) begin
                    m_sdiv[i] = int'(cfg.cfg_div); m_smode[i] = cfg.cfg_mode; m_pend[i] = 1;
                end
                m_rise[i] = nc && !m_clk[i];
                m_fall[i] = !nc && m_clk[i];
                m_clk[i]  = nc;
            end
        end
        if (rst_b) kb = 0;
        else kb++;
        #1;
        for (int i = 0; i < CH; i++) begin
            check($sformatf("clk_out[%0d]", i), int'(clk_out[i]), int'(m_clk[i]));
            check($sformatf("rise[%0d]", i),    int'(rise[i]),    int'(m_rise[i]));
            check($sformatf("fall[%0d]", i),    int'(fall[i]),    int'(m_fall[i]));
        end
        check("cfg_ready", int'(cfg.cfg_ready), int'(!m_pend[cfg.cfg_chan]));
        exp_b = level_at(MODE_TOGGLE, 1, kb) ? '1 : '0;
        check("b clk_out", int'(clk_out_b), int'(exp_b));
        exp_b = (level_at(MODE_TOGGLE, 1, kb) && !level_at(MODE_TOGGLE, 1, kb - 1)) ? '1 : '0;
        check("b rise", int'(rise_b), int'(exp_b));
        exp_b = (!level_at(MODE_TOGGLE, 1, kb) && kb > 0 && level_at(MODE_TOGGLE, 1, kb - 1)) ? '1 : '0;
        check("b fall", int'(fall_b), int'(exp_b));
        check("b cfg_ready", int'(cfg_b.cfg_ready), 1);
    end

    initial begin
        int n;
        rst = 1'b1;  rst_b = 1'b1;
        en = '0;     en_b = '1;
        cfg.cfg_valid = 1'b0; cfg.cfg_chan = '0; cfg.cfg_div = '0; cfg.cfg_mode = MODE_TOGGLE;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_chan = '0; cfg_b.cfg_div = '0; cfg_b.cfg_mode = MODE_TOGGLE;
        step(3);
        check("lit reset clk_out", int'(clk_out), 0);
        check("lit reset ready", int'(cfg.cfg_ready), 1);

        // Default D=1 toggle: period 4.
        rst = 1'b0; rst_b = 1'b0; en = '1;
        step(2);
        check("lit t1 clk_out0 high", int'(clk_out[0]), 1);
        check("lit t1 rise0", int'(rise[0]), 1);
        step(1);
        check("lit t1 clk_out0 hold", int'(clk_out[0]), 1);
        check("lit t1 rise0 single", int'(rise[0]), 0);
        step(1);
        check("lit t1 clk_out0 low", int'(clk_out[0]), 0);
        check("lit t1 fall0", int'(fall[0]), 1);

        // ch2 -> PULSE D=3, deferred to the boundary.
        cfg.cfg_valid = 1'b1; cfg.cfg_chan = 2; cfg.cfg_div = 3; cfg.cfg_mode = MODE_PULSE;
        step(1);
        cfg.cfg_valid = 1'b0;
        check("lit t2 ready pending", int'(cfg.cfg_ready), 0);
        check("lit t2 ch2 unchanged", int'(clk_out[2]), 0);
        step(1);
        check("lit t2 ready applied", int'(cfg.cfg_ready), 1);
        step(3);
        check("lit t2 ch2 pre tick", int'(clk_out[2]), 0);
        step(1);
        check("lit t2 ch2 tick", int'(clk_out[2]), 1);
        check("lit t2 ch2 rise", int'(rise[2]), 1);
        step(1);
        check("lit t2 ch2 after tick", int'(clk_out[2]), 0);
        check("lit t2 ch2 fall", int'(fall[2]), 1);

        // D=0 on ch1 (toggle) and ch3 (pulse).
        cfg.cfg_valid = 1'b1; cfg.cfg_chan = 1; cfg.cfg_div = 0; cfg.cfg_mode = MODE_TOGGLE;
        step(1);
        cfg.cfg_chan = 3; cfg.cfg_mode = MODE_PULSE;
        step(1);
        cfg.cfg_valid = 1'b0; cfg.cfg_chan = 0;
        step(6);
        for (int j = 0; j < 4; j++) begin
            step(1);
            check("lit t3 ch3 held high", int'(clk_out[3]), 1);
            check("lit t3 ch3 no rise", int'(rise[3]), 0);
        end

        // Disable ch1 while high, reprogram, re-enable.
        for (n = 0; n < 8 && !clk_out[1]; n++) step(1);
        check("t4 wait ch1 high", int'(n < 8), 1);
        en[1] = 1'b0;
        step(1);
        check("lit t4 ch1 low", int'(clk_out[1]), 0);
        check("lit t4 ch1 fall", int'(fall[1]), 1);
        cfg.cfg_valid = 1'b1; cfg.cfg_chan = 1; cfg.cfg_div = 2; cfg.cfg_mode = MODE_TOGGLE;
        step(1);
        cfg.cfg_valid = 1'b0; cfg.cfg_chan = 0;
        step(1);
        en[1] = 1'b1;
        step(2);
        check("lit t4 ch1 pre rise", int'(clk_out[1]), 0);
        step(1);
        check("lit t4 ch1 first high", int'(clk_out[1]), 1);
        check("lit t4 ch1 first rise", int'(rise[1]), 1);

        // Back-to-back requests to ch0.
        cfg.cfg_valid = 1'b1; cfg.cfg_chan = 0; cfg.cfg_div = 5; cfg.cfg_mode = MODE_TOGGLE;
        step(1);
        check("lit t5 second held off", int'(cfg.cfg_ready), 0);
        cfg.cfg_div = 2; cfg.cfg_mode = MODE_PULSE;
        for (n = 0; n < 20 && !cfg.cfg_ready; n++) step(1);
        check("t5 wait ready", int'(n < 20), 1);
        step(1);
        cfg.cfg_valid = 1'b0;
        check("lit t5 second accepted", int'(cfg.cfg_ready), 0);
        cfg_b.cfg_valid = 1'b1; cfg_b.cfg_chan = 3; cfg_b.cfg_div = 0; cfg_b.cfg_mode = MODE_PULSE;
        check("lit t5 drop ready", int'(cfg_b.cfg_ready), 1);
        step(2);
        cfg_b.cfg_valid = 1'b0;
        step(20);

        // Reset with a pending load on ch1 while it is high.
        cfg.cfg_valid = 1'b1; cfg.cfg_chan = 1; cfg.cfg_div = 7; cfg.cfg_mode = MODE_TOGGLE;
        step(1);
        cfg.cfg_valid = 1'b0;
        for (n = 0; n < 10 && !cfg.cfg_ready; n++) step(1);
        check("t6 wait apply", int'(n < 10), 1);
        for (n = 0; n < 30 && !rise[1]; n++) step(1);
        check("t6 wait rise", int'(n < 30), 1);
        cfg.cfg_valid = 1'b1; cfg.cfg_div = 4;
        step(1);
        cfg.cfg_valid = 1'b0;
        step(2);
        check("lit t6 ch1 high", int'(clk_out[1]), 1);
        check("lit t6 pending", int'(cfg.cfg_ready), 0);
        rst = 1'b1;
        step(1);
        check("lit t6 clk_out", int'(clk_out), 0);
        check("lit t6 rise", int'(rise), 0);
        check("lit t6 fall", int'(fall), 0);
        check("lit t6 pending cleared", int'(cfg.cfg_ready), 1);
        rst = 1'b0;
        step(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
